regfile_storage: RTL and testbench



---
 rtl/regfile_storage.sv | 90 +++++++++
 tb/tb_regfile_storage.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/regfile_storage.sv
// rtl/regfile_storage.sv - LEGv8 register file storage with per-register pending-write scoreboard
// X0..X30 live in flops; X31 reads as zero and never reports busy.
module regfile_storage #(
   parameter int DATA_W = 64,
   parameter int CNT_W  = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     RegWrite,
   input  logic [4:0]               WriteReg,
   input  logic [DATA_W-1:0]        WriteData,
   input  logic                     issue_en,
   input  logic [4:0]               issue_reg,
   input  logic                     cancel_en,
   input  logic [4:0]               cancel_reg,
   output logic [31:0][DATA_W-1:0]  RegOut,
   output logic [31:0]              busy,
   output logic                     sat_err
);

   localparam int SW = CNT_W + 2;
   localparam logic signed [SW-1:0] CNT_MAX = SW'((1 << CNT_W) - 1);

   logic [DATA_W-1:0] regs_q [31];
   logic [CNT_W-1:0]  cnt_q  [31];
   logic [CNT_W-1:0]  cnt_d  [31];
   logic              sat_err_q, sat_err_d;

   // Returns {overflow, clamped_count}; the signed sum lets underflow be seen as negative.
   function automatic logic [CNT_W:0] next_cnt(input logic [CNT_W-1:0] cnt,
                                               input logic inc,
                                               input logic dec_wb,
                                               input logic dec_cx);
      logic signed [SW-1:0] raw;
      raw = $signed({2'b00, cnt})
          + $signed({{(SW-1){1'b0}}, inc})
          - $signed({{(SW-1){1'b0}}, dec_wb})
          - $signed({{(SW-1){1'b0}}, dec_cx});
      if (raw < 0)
         next_cnt = '0;
      else if (raw > CNT_MAX)
         next_cnt = {1'b1, CNT_MAX[CNT_W-1:0]};
      else
         next_cnt = {1'b0, raw[CNT_W-1:0]};
   endfunction

   always_comb begin
      logic [CNT_W:0] res;
      sat_err_d = sat_err_q;
      res       = '0;
      for (int r = 0; r < 31; r++) begin
         res = next_cnt(cnt_q[r],
                        issue_en  && (issue_reg  == 5'(r)),
                        RegWrite  && (WriteReg   == 5'(r)),
                        cancel_en && (cancel_reg == 5'(r)));
         cnt_d[r] = res[CNT_W-1:0];
         if (res[CNT_W])
            sat_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < 31; r++) begin
            regs_q[r] <= '0;
            cnt_q[r]  <= '0;
         end
         sat_err_q <= 1'b0;
      end else begin
         for (int r = 0; r < 31; r++) begin
            if (RegWrite && (WriteReg == 5'(r)))
               regs_q[r] <= WriteData;
            cnt_q[r] <= cnt_d[r];
         end
         sat_err_q <= sat_err_d;
      end
   end

   always_comb begin
      RegOut = '0;
      busy   = '0;
      for (int r = 0; r < 31; r++) begin
         RegOut[r] = regs_q[r];
         busy[r]   = (cnt_q[r] != '0);
      end
   end

   assign sat_err = sat_err_q;

endmodule

// File: tb/tb_regfile_storage.sv
// tb/tb_regfile_storage.sv - directed self-checking bench for regfile_storage
module tb_regfile_storage;

   localparam int DATA_W = 64;

   logic                    clk;
   logic                    run_clk;
   logic                    reset_n;
   logic                    RegWrite;
   logic [4:0]              WriteReg;
   logic [DATA_W-1:0]       WriteData;
   logic                    issue_en;
   logic [4:0]              issue_reg;
   logic                    cancel_en;
   logic [4:0]              cancel_reg;
   logic [31:0][DATA_W-1:0] RegOut;
   logic [31:0]             busy;
   logic                    sat_err;

   int checks = 0;
   int errors = 0;

   regfile_storage #(.DATA_W(DATA_W), .CNT_W(2)) dut (
      .clk(clk), .reset_n(reset_n),
      .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
      .issue_en(issue_en), .issue_reg(issue_reg),
      .cancel_en(cancel_en), .cancel_reg(cancel_reg),
      .RegOut(RegOut), .busy(busy), .sat_err(sat_err)
   );

   initial clk = 1'b0;
   always #5 clk = run_clk ? ~clk : 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      RegWrite  = 1'b0;
      issue_en  = 1'b0;
      cancel_en = 1'b0;
   endtask

   initial begin
      run_clk    = 1'b0;
      reset_n    = 1'b1;
      RegWrite   = 1'b0;
      WriteReg   = '0;
      WriteData  = '0;
      issue_en   = 1'b0;
      issue_reg  = '0;
      cancel_en  = 1'b0;
      cancel_reg = '0;

      // Reset with no clock edges at all
      #2 reset_n = 1'b0;
      #3;
      for (int i = 0; i < 32; i++) check($sformatf("rst_reg%0d", i), RegOut[i], 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_sat", 64'(sat_err), 64'h0);
      reset_n = 1'b1;
      run_clk = 1'b1;
      #1;

      // First write: no bypass, visible after the edge
      RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 64'hDEADBEEF_00000001;
      #1 check("x5_before_edge", RegOut[5], 64'h0);
      tick();
      check("x5_after_edge", RegOut[5], 64'hDEADBEEF_00000001);
      check("x5_busy", 64'(busy), 64'h0);

      // XZR ignores writes and issue
      RegWrite = 1'b1; WriteReg = 5'd31; WriteData = 64'hFFFF_FFFF_FFFF_FFFF;
      issue_en = 1'b1; issue_reg = 5'd31;
      tick();
      check("xzr_value", RegOut[31], 64'h0);
      check("xzr_busy", 64'(busy), 64'h0);
      check("xzr_sat", 64'(sat_err), 64'h0);

      // Reg 7: fill to saturation, overflow, drain
      for (int k = 0; k < 3; k++) begin
         issue_en = 1'b1; issue_reg = 5'd7;
         tick();
         check($sformatf("r7_busy_issue%0d", k), 64'(busy), 64'h80);
      end
      check("r7_sat_before_ovf", 64'(sat_err), 64'h0);
      issue_en = 1'b1; issue_reg = 5'd7;
      tick();
      check("r7_sat_after_ovf", 64'(sat_err), 64'h1);
      for (int k = 0; k < 3; k++) begin
         RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 64'h700 + 64'(k);
         tick();
         check($sformatf("r7_busy_wb%0d", k), 64'(busy[7]), (k < 2) ? 64'h1 : 64'h0);
      end
      check("r7_value", RegOut[7], 64'h702);

      // Reg 9: issue+WB holds count, WB+cancel drops by 2
      issue_en = 1'b1; issue_reg = 5'd9;
      tick();
      issue_en = 1'b1; issue_reg = 5'd9;
      RegWrite = 1'b1; WriteReg = 5'd9; WriteData = 64'h99;
      tick();
      check("r9_issue_wb_busy", 64'(busy[9]), 64'h1);
      issue_en = 1'b1; issue_reg = 5'd9;
      tick();
      check("r9_cnt2_busy", 64'(busy[9]), 64'h1);
      RegWrite = 1'b1; WriteReg = 5'd9; WriteData = 64'h9A;
      cancel_en = 1'b1; cancel_reg = 5'd9;
      tick();
      check("r9_wb_cancel_busy", 64'(busy[9]), 64'h0);
      check("r9_value", RegOut[9], 64'h9A);

      // Reg 12: cancel at zero clamps; one issue then one cancel returns to idle
      cancel_en = 1'b1; cancel_reg = 5'd12;
      tick();
      check("r12_underflow_busy", 64'(busy), 64'h0);
      check("r12_sat_unchanged", 64'(sat_err), 64'h1);
      issue_en = 1'b1; issue_reg = 5'd12;
      tick();
      check("r12_issue_busy", 64'(busy[12]), 64'h1);
      cancel_en = 1'b1; cancel_reg = 5'd12;
      tick();
      check("r12_cancel_busy", 64'(busy[12]), 64'h0);

      // Load X1..X30, make counters non-zero, then async reset between edges
      for (int i = 1; i <= 30; i++) begin
         RegWrite = 1'b1; WriteReg = 5'(i); WriteData = 64'(i) * 64'h11;
         tick();
      end
      for (int i = 1; i <= 30; i++) check($sformatf("load_x%0d", i), RegOut[i], 64'(i) * 64'h11);
      issue_en = 1'b1; issue_reg = 5'd3;
      tick();
      issue_en = 1'b1; issue_reg = 5'd20;
      tick();
      check("pre_rst_busy", 64'(busy), 64'h0010_0008);
      #2 reset_n = 1'b0;
      #1;
      for (int i = 0; i < 32; i++) check($sformatf("async_rst_reg%0d", i), RegOut[i], 64'h0);
      check("async_rst_busy", 64'(busy), 64'h0);
      check("async_rst_sat", 64'(sat_err), 64'h0);
      #3 reset_n = 1'b1;

      // Post-reset behaves like power-up
      tick();
      RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 64'h1234;
      tick();
      check("post_rst_x0", RegOut[0], 64'h1234);
      check("post_rst_busy", 64'(busy), 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
